amo_exec_unit: RTL and testbench

- Multi-cycle sequencer that executes RV32A atomics (LR.W, SC.W, AMO*.W) against the data memory port; it is the consumer of the AMO ops that the ALU decode path classifies.
- Sits between the core's memory-stage control FSM and the memory arbiter. Owns the single LR/SC reservation register.
- Performs read, compute, write and respond; returns the rd value and an error flag to the core.

---
 rtl/amo_exec_unit.sv | 197 +++++++++++++++++++
 tb/tb_amo_exec_unit.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_exec_unit.sv
// RV32A atomic sequencer: runs LR.W / SC.W / AMO*.W as read-compute-write-respond
// against the data memory port and owns the single LR/SC reservation.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | req_ready high, waiting for an atomic op
// S_READ  | memory read of the old value (LR and AMO ops)
// S_WRITE | memory write of the new value (AMO ops, successful SC)
// S_RESP  | one-cycle rsp_valid pulse carrying rd and the error flag
module amo_exec_unit #(
    parameter int XLEN         = 32,
    parameter int RSV_GRAN_LSB = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_funct5,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_rs2,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rd,
    output logic            rsp_err,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            clear_rsv,
    input  logic            snoop_valid,
    input  logic [XLEN-1:0] snoop_addr
);

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t                       state;
    logic [4:0]                   op_q;
    logic [XLEN-1:0]              rs2_q;
    logic [XLEN-1:0]              rd_q;
    logic                         rsv_valid;
    logic [XLEN-1:RSV_GRAN_LSB]   rsv_addr;

    logic            accept;
    logic            req_bad;
    logic            sc_ok;
    logic            snoop_hit_rsv;
    logic            snoop_hit_lr;
    logic            lr_done;
    logic [XLEN-1:0] new_val;
    logic            unused_bits;

    function automatic logic f5_legal(input logic [4:0] f);
        case (f)
            F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
            F_MIN, F_MAX, F_MINU, F_MAXU: f5_legal = 1'b1;
            default:                      f5_legal = 1'b0;
        endcase
    endfunction

    // Ties keep the old value for all four compare ops.
    function automatic logic [XLEN-1:0] amo_compute(input logic [4:0] f,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        case (f)
            F_ADD:   amo_compute = a + b;
            F_SWAP:  amo_compute = b;
            F_XOR:   amo_compute = a ^ b;
            F_OR:    amo_compute = a | b;
            F_AND:   amo_compute = a & b;
            F_MIN:   amo_compute = ($signed(b) < $signed(a)) ? b : a;
            F_MAX:   amo_compute = ($signed(b) > $signed(a)) ? b : a;
            F_MINU:  amo_compute = (b < a) ? b : a;
            F_MAXU:  amo_compute = (b > a) ? b : a;
            default: amo_compute = a;
        endcase
    endfunction

    assign accept        = req_valid && req_ready;
    assign req_bad       = (req_addr[1:0] != 2'b00) || !f5_legal(req_funct5);
    assign snoop_hit_rsv = snoop_valid && (snoop_addr[XLEN-1:RSV_GRAN_LSB] == rsv_addr);
    assign snoop_hit_lr  = snoop_valid &&
                           (snoop_addr[XLEN-1:RSV_GRAN_LSB] == mem_addr[XLEN-1:RSV_GRAN_LSB]);
    assign sc_ok         = rsv_valid && !clear_rsv && !snoop_hit_rsv &&
                           (req_addr[XLEN-1:RSV_GRAN_LSB] == rsv_addr);
    assign lr_done       = (state == S_READ) && mem_ready && (op_q == F_LR);
    assign new_val       = amo_compute(op_q, mem_rdata, rs2_q);
    assign unused_bits   = ^snoop_addr[RSV_GRAN_LSB-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            op_q      <= 5'b0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rsv_valid <= 1'b0;
            rsv_addr  <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rd    <= '0;
            rsp_err   <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // A clear or snoop landing on the LR completion cycle leaves the reservation invalid.
            if (lr_done) begin
                rsv_valid <= !(clear_rsv || snoop_hit_lr);
                rsv_addr  <= mem_addr[XLEN-1:RSV_GRAN_LSB];
            end else if (clear_rsv || snoop_hit_rsv || (accept && (req_funct5 == F_SC))) begin
                rsv_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        op_q      <= req_funct5;
                        rs2_q     <= req_rs2;
                        mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                        if (req_bad) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rd    <= '0;
                        end else if (req_funct5 == F_SC) begin
                            if (sc_ok) begin
                                state     <= S_WRITE;
                                mem_valid <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_wdata <= req_rs2;
                                rd_q      <= '0;
                            end else begin
                                state     <= S_RESP;
                                rsp_valid <= 1'b1;
                                rsp_rd    <= XLEN'(1);
                            end
                        end else begin
                            state     <= S_READ;
                            mem_valid <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end
                S_READ: begin
                    if (mem_ready) begin
                        rd_q <= mem_rdata;
                        if (op_q == F_LR) begin
                            state     <= S_RESP;
                            mem_valid <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_rd    <= mem_rdata;
                        end else begin
                            state     <= S_WRITE;
                            mem_we    <= 1'b1;
                            mem_wdata <= new_val;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        state     <= S_RESP;
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rd    <= rd_q;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rd    <= '0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amo_exec_unit.sv
// Scoreboard bench for amo_exec_unit: a word-level memory/reservation model
// predicts responses and memory transfers, and a monitor checks them as they appear.
module tb_amo_exec_unit;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_funct5 = 5'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_rs2 = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rd;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        clear_rsv = 1'b0;
    logic        snoop_valid = 1'b0;
    logic [31:0] snoop_addr = '0;

    amo_exec_unit #(.XLEN(32), .RSV_GRAN_LSB(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct5(req_funct5),
        .req_addr(req_addr), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .clear_rsv(clear_rsv), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rd; logic err; int lat; } rsp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int lat; } mtx_t;

    rsp_t        exp_rsp[$];
    mtx_t        exp_mem[$];
    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    bit          rsv_v = 0;
    logic [29:0] rsv_a = '0;

    int checks = 0, errors = 0;
    int acc_cyc = 0, rsp_seen = 0;
    bit lat_on = 1, rnd_stall = 0;
    int rd_stall = 0, wr_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 32'h0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        phys_mem[a] = v;
        ref_mem[a]  = v;
    endtask

    function automatic bit is_legal(input logic [4:0] f);
        return f == F_ADD || f == F_SWAP || f == F_LR || f == F_SC || f == F_XOR ||
               f == F_OR  || f == F_AND  || f == F_MIN || f == F_MAX ||
               f == F_MINU || f == F_MAXU;
    endfunction

    function automatic logic [31:0] amo_ref(input logic [4:0] f, input logic [31:0] o,
                                            input logic [31:0] d);
        int so = o;
        int sd = d;
        case (f)
            F_ADD:   return o + d;
            F_SWAP:  return d;
            F_XOR:   return o ^ d;
            F_OR:    return o | d;
            F_AND:   return o & d;
            F_MIN:   return (sd < so) ? d : o;
            F_MAX:   return (sd > so) ? d : o;
            F_MINU:  return (d < o) ? d : o;
            F_MAXU:  return (d > o) ? d : o;
            default: return o;
        endcase
    endfunction

    function automatic int lat(input int n);
        return lat_on ? n : -1;
    endfunction

    // Reference model: predicts the whole op at issue time from the architectural rules.
    task automatic model(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] d,
                         input bit clr_acc, input bit clr_c1);
        logic [31:0] w;
        logic [31:0] old;
        logic [31:0] nv;
        bit err, ok;
        w   = {a[31:2], 2'b00};
        old = ref_rd(w);
        err = (a[1:0] != 2'b00) || !is_legal(f5);
        if (err) begin
            exp_rsp.push_back('{rd: 32'h0, err: 1'b1, lat: lat(1)});
            if (f5 == F_SC) rsv_v = 0;
        end else if (f5 == F_SC) begin
            ok = rsv_v && (rsv_a == a[31:2]) && !clr_acc;
            rsv_v = 0;
            if (ok) begin
                exp_mem.push_back('{we: 1'b1, addr: w, wdata: d, lat: lat(1)});
                ref_mem[w] = d;
                exp_rsp.push_back('{rd: 32'h0, err: 1'b0, lat: lat(2)});
            end else begin
                exp_rsp.push_back('{rd: 32'h1, err: 1'b0, lat: lat(1)});
            end
        end else if (f5 == F_LR) begin
            exp_mem.push_back('{we: 1'b0, addr: w, wdata: 32'h0, lat: lat(1)});
            exp_rsp.push_back('{rd: old, err: 1'b0, lat: lat(2)});
            rsv_v = !clr_c1;
            rsv_a = a[31:2];
        end else begin
            nv = amo_ref(f5, old, d);
            exp_mem.push_back('{we: 1'b0, addr: w, wdata: 32'h0, lat: lat(1)});
            exp_mem.push_back('{we: 1'b1, addr: w, wdata: nv, lat: lat(2)});
            ref_mem[w] = nv;
            exp_rsp.push_back('{rd: old, err: 1'b0, lat: lat(3)});
        end
        if ((err || f5 != F_LR) && (clr_acc || clr_c1)) rsv_v = 0;
    endtask

    task automatic wait_ready_and_drive(input logic [4:0] f5, input logic [31:0] a,
                                        input logic [31:0] d, input bit clr_acc, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: req_ready stayed 0 for %0d cycles, expected 1", n);
            exp_rsp.delete();
            exp_mem.delete();
            return;
        end
        req_valid  = 1'b1;
        req_funct5 = f5;
        req_addr   = a;
        req_rs2    = d;
        clear_rsv  = clr_acc;
        acc_cyc    = cyc;
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_rs2    = $urandom;
        req_funct5 = 5'($urandom);
        chk("req_ready_busy", {31'b0, req_ready}, 32'h0);
    endtask

    task automatic issue(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] d,
                         input bit clr_acc = 0, input bit clr_c1 = 0);
        int seen0;
        int n = 0;
        bit ok;
        model(f5, a, d, clr_acc, clr_c1);
        seen0 = rsp_seen;
        wait_ready_and_drive(f5, a, d, clr_acc, ok);
        if (!ok) return;
        clear_rsv = clr_c1;
        @(negedge clk);
        clear_rsv = 1'b0;
        while (rsp_seen == seen0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rsp_seen == seen0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles for funct5 %05b, expected one", n, f5);
            exp_rsp.delete();
            exp_mem.delete();
        end
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear_rsv = 1'b1;
        @(negedge clk);
        clear_rsv = 1'b0;
        rsv_v = 0;
    endtask

    task automatic snoop_pulse(input logic [31:0] a);
        @(negedge clk);
        snoop_valid = 1'b1;
        snoop_addr  = a;
        @(negedge clk);
        snoop_valid = 1'b0;
        if (rsv_v && a[31:2] == rsv_a) rsv_v = 0;
    endtask

    // Memory responder: each new transfer gets a stall count, then mem_ready for one cycle.
    bit pend = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!mem_valid) begin
            mem_ready = 1'b0;
            pend = 0;
        end else begin
            if (!pend) begin
                pend = 1;
                stall_cnt = rnd_stall ? int'($urandom_range(0, 3)) : (mem_we ? wr_stall : rd_stall);
            end
            if (stall_cnt > 0) begin
                mem_ready = 1'b0;
                stall_cnt--;
            end else begin
                mem_ready = 1'b1;
                pend = 0;
            end
        end
        mem_rdata = mem_valid ? phys_rd(mem_addr) : 32'h0;
    end

    // Monitor: pops expectations whenever the DUT presents a response or a memory transfer.
    rsp_t        m_r;
    mtx_t        m_m;
    bit          held = 0;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_seen++;
            if (exp_rsp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rd 0x%08h err %0b, expected no response", rsp_rd, rsp_err);
            end else begin
                m_r = exp_rsp.pop_front();
                chk("rsp_rd", rsp_rd, m_r.rd);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_r.err});
                if (m_r.lat >= 0) chk("rsp_latency", 32'(cyc - acc_cyc), 32'(m_r.lat));
            end
        end
        if (mem_valid) begin
            if (held) begin
                chk("stall_mem_we", {31'b0, mem_we}, {31'b0, h_we});
                chk("stall_mem_addr", mem_addr, h_addr);
                chk("stall_mem_wdata", mem_wdata, h_wdata);
            end
            if (mem_ready) begin
                held = 0;
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem: got we %0b addr 0x%08h, expected no transfer", mem_we, mem_addr);
                end else begin
                    m_m = exp_mem.pop_front();
                    chk("mem_we", {31'b0, mem_we}, {31'b0, m_m.we});
                    chk("mem_addr", mem_addr, m_m.addr);
                    if (m_m.we) chk("mem_wdata", mem_wdata, m_m.wdata);
                    if (m_m.lat >= 0) chk("mem_latency", 32'(cyc - acc_cyc), 32'(m_m.lat));
                end
                if (mem_we) phys_mem[mem_addr] = mem_wdata;
            end else begin
                held    = 1;
                h_we    = mem_we;
                h_addr  = mem_addr;
                h_wdata = mem_wdata;
            end
        end else begin
            held = 0;
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    logic [4:0] rnd_ops [14];
    logic [4:0] bad_ops [4];
    initial begin
        logic [31:0] a, d, old;
        logic [4:0]  f;
        int seen0, n;
        bit ok;
        rnd_ops = '{F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND, F_MIN, F_MAX,
                    F_MINU, F_MAXU, F_LR, F_SC, 5'b00101};
        bad_ops = '{5'b00101, 5'b00110, 5'b01111, 5'b11111};
        for (int i = 0; i < 8; i++) preload(32'h1000 + 32'(i * 4), $urandom);

        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'h0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset_rsp_rd", rsp_rd, 32'h0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("reset_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk("reset_mem_we", {31'b0, mem_we}, 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("req_ready_after_reset", {31'b0, req_ready}, 32'h1);

        preload(32'h100, 32'h7FFF_FFFF);
        issue(F_ADD, 32'h100, 32'h1);

        preload(32'h200, 32'hDEAD_BEEF);
        issue(F_LR, 32'h200, 32'h0);
        issue(F_SC, 32'h200, 32'h55);
        issue(F_SC, 32'h200, 32'h66);

        issue(F_LR, 32'h200, 32'h0);
        clear_pulse();
        issue(F_SC, 32'h200, 32'h77);
        issue(F_LR, 32'h200, 32'h0);
        snoop_pulse(32'h202);
        issue(F_SC, 32'h200, 32'h88);
        issue(F_LR, 32'h200, 32'h0);
        snoop_pulse(32'h204);
        issue(F_SC, 32'h200, 32'h99);

        preload(32'h300, 32'hFFFF_FFFF);
        issue(F_MIN, 32'h300, 32'h1);
        preload(32'h300, 32'hFFFF_FFFF);
        issue(F_MINU, 32'h300, 32'h1);
        issue(F_MAX, 32'h300, 32'h1);
        issue(F_MAXU, 32'h300, 32'h1);

        issue(F_SWAP, 32'h102, 32'h1234);
        issue(5'b00101, 32'h100, 32'h1);
        issue(F_LR, 32'h200, 32'h0);
        issue(F_SC, 32'h201, 32'h1);
        issue(F_SC, 32'h200, 32'h1);

        issue(F_LR, 32'h200, 32'h0);
        issue(F_SC, 32'h200, 32'hAA, 1'b1, 1'b0);
        issue(F_LR, 32'h200, 32'h0, 1'b0, 1'b1);
        issue(F_SC, 32'h200, 32'hBB);
        issue(F_LR, 32'h200, 32'h0);
        issue(F_LR, 32'h100, 32'h0);
        issue(F_SC, 32'h200, 32'hCC);

        issue(F_LR, 32'h200, 32'h0);
        lat_on = 0;
        rd_stall = 5;
        wr_stall = 3;
        preload(32'h400, 32'h0F0F_0000);
        issue(F_OR, 32'h400, 32'h0000_00F0);

        preload(32'h404, 32'h1111_0000);
        old = ref_rd(32'h404);
        model(F_OR, 32'h404, 32'h0000_2222, 1'b0, 1'b0);
        wait_ready_and_drive(F_OR, 32'h404, 32'h0000_2222, 1'b0, ok);
        n = 0;
        while (!(mem_valid && mem_we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_write_phase", {31'b0, mem_valid && mem_we}, 32'h1);
        seen0 = rsp_seen;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk("async_reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        exp_rsp.delete();
        exp_mem.delete();
        ref_mem[32'h404] = old;
        rsv_v = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_rsp_across_reset", 32'(rsp_seen - seen0), 32'h0);
        chk("req_ready_after_midop_reset", {31'b0, req_ready}, 32'h1);
        rd_stall = 0;
        wr_stall = 0;
        lat_on = 1;
        issue(F_SC, 32'h200, 32'hDD);
        issue(F_LR, 32'h404, 32'h0);

        lat_on = 0;
        rnd_stall = 1;
        for (int i = 0; i < 300; i++) begin
            f = rnd_ops[$urandom_range(0, 13)];
            if (f == 5'b00101) f = bad_ops[$urandom_range(0, 3)];
            a = 32'h1000 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            issue(f, a, d);
            case ($urandom_range(0, 9))
                0: clear_pulse();
                1: snoop_pulse(32'h1000 + 32'($urandom_range(0, 31)));
                default: ;
            endcase
        end

        repeat (5) @(negedge clk);
        chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'h0);
        chk("exp_mem_drained", 32'(exp_mem.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
